// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer feeding the DDS frequency word K: start-to-stop stepping with dwell, abort and done.
// Optional `define SWEEP_TRIANGLE_EN: reverse at f_stop and sweep back to f_start (triangle) instead of sawtooth.
module dds_sweep_ctrl #(
    parameter int KW = 32,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [KW-1:0] f_start,
    input  logic [KW-1:0] f_stop,
    input  logic [KW-1:0] f_step,
    input  logic [DW-1:0] dwell,
    input  logic          mode,
    output logic [KW-1:0] K_out,
    output logic          k_upd,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {IDLE, DWELL, STEP} state_t;

    localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

    state_t        state, state_nxt;
    logic [KW-1:0] cfg_start, cfg_stop, cfg_step;
    logic [DW-1:0] cfg_dwell;
    logic          cfg_mode, dir_up;
    logic [DW-1:0] cnt, cnt_nxt;
    logic [KW-1:0] k_nxt;
    logic          upd_nxt, busy_nxt, done_nxt;
    logic          accept, finish;
    logic [DW-1:0] dwell_eff;

    // One step toward tgt, widened by a bit so overflow/underflow is caught and clamped.
    function automatic logic [KW-1:0] step_toward(input logic [KW-1:0] k, input logic [KW-1:0] s,
                                                  input logic [KW-1:0] tgt, input logic up);
        logic [KW:0] nxt;
        logic        clamp;
        if (up) begin
            nxt   = {1'b0, k} + {1'b0, s};
            clamp = nxt[KW] || (nxt[KW-1:0] > tgt);
        end else begin
            nxt   = {1'b0, k} - {1'b0, s};
            clamp = nxt[KW] || (nxt[KW-1:0] < tgt);
        end
        if (s == '0)
            clamp = 1'b1;
        return clamp ? tgt : nxt[KW-1:0];
    endfunction

    assign accept    = (state == IDLE) && start && !abort;
    assign dwell_eff = (dwell == '0) ? ONE : dwell;

`ifdef SWEEP_TRIANGLE_EN
    logic          rev, rev_nxt;
    logic [KW-1:0] target;
    assign target = rev ? cfg_start : cfg_stop;
    assign finish = !cfg_mode && (K_out == target) && (rev || (cfg_start == cfg_stop));
`else
    assign finish = !cfg_mode && (K_out == cfg_stop);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // The start cycle counts as the first dwell cycle of f_start, so a 1-cycle dwell goes straight to STEP.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (dwell_eff == ONE) ? STEP : DWELL;
            DWELL:   if (cnt <= ONE) state_nxt = STEP;
            STEP:    state_nxt = finish ? IDLE : DWELL;
            default: state_nxt = IDLE;
        endcase
        if (abort && (state != IDLE))
            state_nxt = IDLE;
    end

    always_comb begin
        k_nxt    = K_out;
        upd_nxt  = 1'b0;
        busy_nxt = busy;
        done_nxt = 1'b0;
        cnt_nxt  = cnt;
`ifdef SWEEP_TRIANGLE_EN
        rev_nxt  = rev;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    k_nxt    = f_start;
                    upd_nxt  = 1'b1;
                    busy_nxt = 1'b1;
                    cnt_nxt  = dwell_eff - ONE;
`ifdef SWEEP_TRIANGLE_EN
                    rev_nxt  = 1'b0;
`endif
                end
            end
            DWELL: cnt_nxt = cnt - ONE;
            STEP: begin
                if (finish) begin
                    done_nxt = 1'b1;
                    busy_nxt = 1'b0;
                end else begin
                    upd_nxt = 1'b1;
                    cnt_nxt = cfg_dwell;
`ifdef SWEEP_TRIANGLE_EN
                    // At an endpoint turn around, so the endpoint word is never repeated.
                    if (K_out != target)
                        k_nxt = step_toward(K_out, cfg_step, target, dir_up ^ rev);
                    else if (cfg_start == cfg_stop)
                        k_nxt = cfg_start;
                    else begin
                        rev_nxt = !rev;
                        k_nxt   = step_toward(K_out, cfg_step, rev ? cfg_stop : cfg_start, dir_up ^ !rev);
                    end
`else
                    k_nxt = (K_out == cfg_stop) ? cfg_start : step_toward(K_out, cfg_step, cfg_stop, dir_up);
`endif
                end
            end
            default: ;
        endcase
        if (abort && (state != IDLE)) begin
            k_nxt    = K_out;
            upd_nxt  = 1'b0;
            busy_nxt = 1'b0;
            done_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            K_out     <= '0;
            k_upd     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cnt       <= '0;
            cfg_start <= '0;
            cfg_stop  <= '0;
            cfg_step  <= '0;
            cfg_dwell <= ONE;
            cfg_mode  <= 1'b0;
            dir_up    <= 1'b1;
`ifdef SWEEP_TRIANGLE_EN
            rev       <= 1'b0;
`endif
        end else begin
            K_out <= k_nxt;
            k_upd <= upd_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            cnt   <= cnt_nxt;
`ifdef SWEEP_TRIANGLE_EN
            rev   <= rev_nxt;
`endif
            if (accept) begin
                cfg_start <= f_start;
                cfg_stop  <= f_stop;
                cfg_step  <= f_step;
                cfg_dwell <= dwell_eff;
                cfg_mode  <= mode;
                dir_up    <= (f_start <= f_stop);
            end
        end
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Randomized self-checking bench for dds_sweep_ctrl using a word-list sweep model.
// Define SWEEP_TRIANGLE_EN for both bench and design to check the triangle build.
`timescale 1ns/1ps
module tb_dds_sweep_ctrl;
    localparam int KW = 32;
    localparam int DW = 16;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          start   = 1'b0;
    logic          abort   = 1'b0;
    logic          mode    = 1'b0;
    logic [KW-1:0] f_start = '0;
    logic [KW-1:0] f_stop  = '0;
    logic [KW-1:0] f_step  = '0;
    logic [DW-1:0] dwell   = '0;
    logic [KW-1:0] K_out;
    logic          k_upd, busy, done;

    dds_sweep_ctrl #(.KW(KW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .f_start(f_start), .f_stop(f_stop), .f_step(f_step), .dwell(dwell), .mode(mode),
        .K_out(K_out), .k_upd(k_upd), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic [KW-1:0] k;
        logic          upd;
        logic          busy;
        logic          done;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          cur;
    logic [KW-1:0] model_words[$];
    logic [KW-1:0] exp_words[$];
    logic [KW-1:0] upd_log[$];
    bit            model_finite;
    logic [KW-1:0] last_k = '0;
    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    int            done_cnt = 0;
    int            done_cyc = 0;
    int            last_start_cyc = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic checkOutput(input string name, input logic [KW-1:0] ek, input logic eu,
                               input logic eb, input logic ed);
        checks++;
        if (K_out !== ek || k_upd !== eu || busy !== eb || done !== ed) begin
            failures++;
            $display("[TB] FAIL %s cyc=%0d got K=%h upd=%b busy=%b done=%b want K=%h upd=%b busy=%b done=%b",
                     name, cyc, K_out, k_upd, busy, done, ek, eu, eb, ed);
        end
    endtask

    task automatic checkValue(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            failures++;
            $display("[TB] FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Every cycle: DUT against the expected trace, or against the quiet idle state between sweeps.
    always @(negedge clk) begin
        if (!rst_n) begin
            checkOutput("reset_state", '0, 1'b0, 1'b0, 1'b0);
        end else begin
            if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
                cur    = exp_q.pop_front();
                last_k = cur.k;
                checkOutput("trace", cur.k, cur.upd, cur.busy, cur.done);
            end else begin
                checkOutput("idle", last_k, 1'b0, 1'b0, 1'b0);
            end
            if (k_upd) upd_log.push_back(K_out);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    function automatic longint toward(input longint w, input longint stp, input longint tgt, input bit up);
        longint n;
        n = up ? w + stp : w - stp;
        if (stp == 0 || (up && n > tgt) || (!up && n < tgt))
            n = tgt;
        return n;
    endfunction

    // Ordered list of words the sweep visits; finite only when a single sweep ends.
    task automatic buildWords(input logic [KW-1:0] s, input logic [KW-1:0] e, input logic [KW-1:0] st,
                              input logic md, input int cap);
        longint w, se, ee, stp, tgt;
        bit     up, back;
        w = s; se = s; ee = e; stp = st;
        up = (se <= ee);
        back = 1'b0;
        model_finite = 1'b0;
        model_words.delete();
        model_words.push_back(s);
        while (model_words.size() < cap) begin
            tgt = back ? se : ee;
            if (w == tgt) begin
`ifdef SWEEP_TRIANGLE_EN
                if (back || se == ee) begin
                    if (!md) begin model_finite = 1'b1; break; end
                    back = 1'b0;
                    w = (se == ee) ? se : toward(w, stp, ee, up);
                end else begin
                    back = 1'b1;
                    w = toward(w, stp, se, !up);
                end
`else
                if (!md) begin model_finite = 1'b1; break; end
                w = se;
`endif
            end else begin
                w = toward(w, stp, tgt, back ? !up : up);
            end
            model_words.push_back(w[KW-1:0]);
        end
    endtask

    // First word lasts d cycles, every later word d+1; a finished single sweep adds the done cycle.
    task automatic buildTrace(input int t0, input int d);
        int   c;
        exp_t ent;
        c = t0 + 1;
        for (int i = 0; i < model_words.size(); i++) begin
            for (int j = 0; j < ((i == 0) ? d : d + 1); j++) begin
                ent.cyc = c; ent.k = model_words[i]; ent.upd = (j == 0); ent.busy = 1'b1; ent.done = 1'b0;
                exp_q.push_back(ent);
                c++;
            end
        end
        if (model_finite) begin
            ent.cyc = c; ent.k = model_words[model_words.size()-1];
            ent.upd = 1'b0; ent.busy = 1'b0; ent.done = 1'b1;
            exp_q.push_back(ent);
        end
    endtask

    task automatic applyStimulus(input logic [KW-1:0] s, input logic [KW-1:0] e, input logic [KW-1:0] st,
                                 input logic [DW-1:0] dw, input logic md,
                                 input int abort_after, input int reset_after);
        int d, len, ab;
        @(posedge clk); #2;
        f_start = s; f_stop = e; f_step = st; dwell = dw; mode = md;
        start = 1'b1; abort = 1'b0;
        last_start_cyc = cyc;
        d = (dw == '0) ? 1 : int'(dw);
        buildWords(s, e, st, md, 64);
        buildTrace(cyc, d);
        len = exp_q.size();
        ab = abort_after;
        if (!model_finite && (ab < 1 || ab >= len))
            ab = $urandom_range(len - 1, 1);
        for (int i = 1; i <= len + 3; i++) begin
            @(posedge clk); #2;
            start = 1'b0; abort = 1'b0;
            f_start = $urandom; f_stop = $urandom; f_step = $urandom;
            dwell = 16'($urandom); mode = 1'($urandom);
            if (i == reset_after) begin
                rst_n = 1'b0;
                #1;
                checkOutput("async_reset", '0, 1'b0, 1'b0, 1'b0);
                exp_q.delete();
                last_k = '0;
                @(posedge clk); #2;
                rst_n = 1'b1;
                break;
            end
            if (i == ab) begin
                abort = 1'b1;
                while (exp_q.size() != 0 && exp_q[exp_q.size()-1].cyc > cyc)
                    void'(exp_q.pop_back());
            end
            if (exp_q.size() != 0 && exp_q[0].cyc == cyc && exp_q[0].busy && $urandom_range(0, 7) == 0)
                start = 1'b1;
            if (exp_q.size() == 0) break;
        end
        @(posedge clk); #2;
        start = 1'b0; abort = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL sweep_timeout pending=%0d want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic startWithAbort();
        @(posedge clk); #2;
        f_start = $urandom; f_stop = $urandom; f_step = $urandom; dwell = 16'd2;
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #2;
        start = 1'b0; abort = 1'b1;
        @(posedge clk); #2;
        abort = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checkValue("start_abort_busy", longint'(busy), 0);
    endtask

    task automatic compareWords(input string name);
        checkValue({name, "_count"}, upd_log.size(), exp_words.size());
        for (int i = 0; i < upd_log.size() && i < exp_words.size(); i++)
            checkValue({name, "_word"}, upd_log[i], exp_words[i]);
    endtask

    task automatic runRandom(input int n_sweeps);
        logic [KW-1:0] s, e, st;
        longint        diff;
        int            kind, ab;
        for (int n = 0; n < n_sweeps; n++) begin
            kind = $urandom_range(0, 5);
            s = $urandom; e = $urandom;
            if (kind == 0) begin s = 32'($urandom_range(0, 200)); e = 32'($urandom_range(0, 200)); end
            if (kind == 1) begin s = 32'hFFFF_FF00 | 32'($urandom_range(0, 255)); e = 32'hFFFF_FFFF; end
            if (kind == 2) begin s = 32'($urandom_range(0, 255)); e = '0; end
            diff = (s > e) ? longint'(s) - longint'(e) : longint'(e) - longint'(s);
            st = 32'(diff / longint'($urandom_range(1, 10)) + longint'($urandom_range(0, 2)));
            if (kind == 3) st = $urandom;
            if (kind == 4) e = s;
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : -1;
            applyStimulus(s, e, st, 16'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), ab, -1);
            if ($urandom_range(0, 4) == 0) startWithAbort();
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        buildWords(32'd100, 32'd130, 32'd10, 1'b0, 64);
        checkValue("model_up_count", model_words.size(), 4);
        checkValue("model_up_last", model_words[3], 130);
        buildWords(32'd1000, 32'd975, 32'd10, 1'b0, 64);
        checkValue("model_clamp_word3", model_words[3], 975);
        buildWords(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 1'b0, 64);
        checkValue("model_ovf_word1", model_words[1], 32'hFFFF_FFFF);

        upd_log.delete(); done_cnt = 0;
        applyStimulus(32'd100, 32'd130, 32'd10, 16'd3, 1'b0, -1, -1);
        exp_words = '{32'd100, 32'd110, 32'd120, 32'd130};
        compareWords("up");
        checkValue("up_done_count", done_cnt, 1);
        checkValue("up_done_cycle", done_cyc - last_start_cyc, 16);

        upd_log.delete(); done_cnt = 0;
        applyStimulus(32'd1000, 32'd975, 32'd10, 16'd1, 1'b0, -1, -1);
        exp_words = '{32'd1000, 32'd990, 32'd980, 32'd975};
        compareWords("clamp_down");
        checkValue("clamp_done_cycle", done_cyc - last_start_cyc, 8);

        upd_log.delete();
        applyStimulus(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd2, 1'b0, -1, -1);
        exp_words = '{32'hFFFF_FFF0, 32'hFFFF_FFFF};
        compareWords("overflow");

        upd_log.delete(); done_cnt = 0;
        applyStimulus(32'd0, 32'd20, 32'd10, 16'd2, 1'b1, 4, -1);
        exp_words = '{32'd0, 32'd10};
        compareWords("cont_abort");
        checkValue("cont_abort_done", done_cnt, 0);
        checkValue("cont_abort_hold", K_out, 10);

        upd_log.delete();
        applyStimulus(32'd0, 32'd20, 32'd10, 16'd1, 1'b0, -1, -1);
`ifdef SWEEP_TRIANGLE_EN
        exp_words = '{32'd0, 32'd10, 32'd20, 32'd10, 32'd0};
        checkValue("shape_done_cycle", done_cyc - last_start_cyc, 10);
`else
        exp_words = '{32'd0, 32'd10, 32'd20};
        checkValue("shape_done_cycle", done_cyc - last_start_cyc, 6);
`endif
        compareWords("shape");

        upd_log.delete();
        applyStimulus(32'd50, 32'd80, 32'd0, 16'd2, 1'b0, -1, -1);
        exp_words = '{32'd50, 32'd80};
        compareWords("zero_step");

        upd_log.delete();
        applyStimulus(32'd7, 32'd7, 32'd5, 16'd2, 1'b0, -1, -1);
        exp_words = '{32'd7};
        compareWords("one_word");
        checkValue("one_word_done_cycle", done_cyc - last_start_cyc, 3);

        applyStimulus(32'd100, 32'd200, 32'd10, 16'd2, 1'b1, -1, 5);
        startWithAbort();

        runRandom(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
